// File: rtl/int_priority_ctrl.sv
// ----------------------------------------------------------------------------
// int_priority_ctrl : fixed-priority interrupt/reset arbiter with per-source
// edge/level and maskable/non-maskable configuration, req/ack/done handshake.
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module int_priority_ctrl #(
   parameter int                    NUM_SRC      = 3,
   parameter int                    ID_W         = 2,
   parameter logic [NUM_SRC-1:0]    EDGE_MASK    = 3'b010,
   parameter logic [NUM_SRC-1:0]    NOMASK_MASK  = 3'b011,
   parameter logic [16*NUM_SRC-1:0] VECTOR_TABLE = 48'hFFFE_FFFA_FFFC
) (
   input  logic               phi2,
   input  logic               RES,
   input  logic [NUM_SRC-1:0] int_n,
   input  logic               i_flag,
   input  logic               ack,
   input  logic               done,
   output logic               req,
   output logic [ID_W-1:0]    req_id,
   output logic [15:0]        req_vec,
   output logic               in_service,
   output logic [NUM_SRC-1:0] pending
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } state_t;

   state_t               state_q;
   logic [NUM_SRC-1:0]   edge_q;
   logic [NUM_SRC-1:0]   edge_d;
   logic [NUM_SRC-1:0]   prev_n_q;
   logic                 req_q;
   logic [ID_W-1:0]      req_id_q;
   logic [15:0]          req_vec_q;
   logic                 in_service_q;

   logic [NUM_SRC-1:0]   edge_det;
   logic [NUM_SRC-1:0]   pending_w;
   logic [NUM_SRC-1:0]   eligible;
   logic [NUM_SRC-1:0]   ack_clr;
   logic                 ack_fire;
   logic                 win_any;
   logic [ID_W-1:0]      win_id;
   logic [15:0]          win_vec;

   // A falling edge counts as pending in the same cycle it is seen, which
   // gives the single-cycle int_n-to-req latency.
   assign edge_det  = EDGE_MASK & prev_n_q & ~int_n;
   assign pending_w = (EDGE_MASK & (edge_q | edge_det)) | (~EDGE_MASK & ~int_n);
   assign eligible  = pending_w & (NOMASK_MASK | {NUM_SRC{~i_flag}});
   assign ack_fire  = (state_q == REQ) && ack;

   always_comb begin
      win_any = 1'b0;
      win_id  = '0;
      win_vec = VECTOR_TABLE[15:0];
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            win_any = 1'b1;
            win_id  = ID_W'(i);
            win_vec = VECTOR_TABLE[16*i +: 16];
         end
      end
   end

   always_comb begin
      ack_clr = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         ack_clr[i] = ack_fire && (req_id_q == ID_W'(i));
      end
   end

   // A same-cycle edge re-arms the latch being cleared so the event survives.
   assign edge_d = ((edge_q & ~ack_clr) | edge_det) & EDGE_MASK;

   always_ff @(posedge phi2) begin
      if (RES) begin
         edge_q   <= '0;
         prev_n_q <= '1;
      end else begin
         edge_q   <= edge_d;
         prev_n_q <= int_n;
      end
   end

   always_ff @(posedge phi2) begin
      if (RES) begin
         state_q      <= IDLE;
         req_q        <= 1'b0;
         req_id_q     <= '0;
         req_vec_q    <= VECTOR_TABLE[15:0];
         in_service_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (win_any) begin
                  req_q     <= 1'b1;
                  req_id_q  <= win_id;
                  req_vec_q <= win_vec;
                  state_q   <= REQ;
               end
            end
            REQ: begin
               if (ack) begin
                  req_q        <= 1'b0;
                  in_service_q <= 1'b1;
                  state_q      <= SERVICE;
               end else if (win_any) begin
                  // Winner only differs from req_id on hijack or withdrawal.
                  req_id_q  <= win_id;
                  req_vec_q <= win_vec;
               end else begin
                  req_q   <= 1'b0;
                  state_q <= IDLE;
               end
            end
            SERVICE: begin
               if (done) begin
                  in_service_q <= 1'b0;
                  state_q      <= IDLE;
               end
            end
            default: begin
               req_q        <= 1'b0;
               in_service_q <= 1'b0;
               state_q      <= IDLE;
            end
         endcase
      end
   end

   assign req        = req_q;
   assign req_id     = req_id_q;
   assign req_vec    = req_vec_q;
   assign in_service = in_service_q;
   assign pending    = pending_w;

endmodule

`default_nettype wire

// File: tb/tb_int_priority_ctrl.sv
// ----------------------------------------------------------------------------
// tb_int_priority_ctrl : directed stimulus with a req_id/req_vec scoreboard.
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_int_priority_ctrl;

   logic        phi2 = 1'b0;
   logic        RES;
   logic [2:0]  int_n;
   logic        i_flag;
   logic        ack;
   logic        done;
   logic        req;
   logic [1:0]  req_id;
   logic [15:0] req_vec;
   logic        in_service;
   logic [2:0]  pending;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic [1:0]  id;
      logic [15:0] vec;
   } exp_t;

   exp_t exp_q[$];

   int_priority_ctrl dut (
      .phi2       (phi2),
      .RES        (RES),
      .int_n      (int_n),
      .i_flag     (i_flag),
      .ack        (ack),
      .done       (done),
      .req        (req),
      .req_id     (req_id),
      .req_vec    (req_vec),
      .in_service (in_service),
      .pending    (pending)
   );

   always #5 phi2 = ~phi2;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge phi2);
      #1;
   endtask

   task automatic expect_req(input logic [1:0] id, input logic [15:0] vec);
      exp_t e;
      e.id  = id;
      e.vec = vec;
      exp_q.push_back(e);
   endtask

   // Monitor: every new request (req rising or req_id changing) pops one entry.
   initial begin
      logic       prev_req = 1'b0;
      logic [1:0] prev_id  = 2'd0;
      exp_t       e;
      forever begin
         @(negedge phi2);
         if (req && (!prev_req || req_id != prev_id)) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_req", {14'd0, req_id, req_vec}, 32'hDEAD);
            end else begin
               e = exp_q.pop_front();
               chk("req_id", {30'd0, req_id}, {30'd0, e.id});
               chk("req_vec", {16'd0, req_vec}, {16'd0, e.vec});
            end
         end
         prev_req = req;
         prev_id  = req_id;
      end
   end

   initial begin
      RES = 1'b1; int_n = 3'b111; i_flag = 1'b1; ack = 1'b0; done = 1'b0;
      tick(2);
      chk("rst_req", {31'd0, req}, 0);
      chk("rst_vec", {16'd0, req_vec}, 32'hFFFC);
      RES = 1'b0;
      tick(10);
      chk("idle_req", {31'd0, req}, 0);
      chk("idle_pending", {29'd0, pending}, 0);
      chk("idle_insvc", {31'd0, in_service}, 0);
      chk("idle_vec", {16'd0, req_vec}, 32'hFFFC);
      chk("idle_id", {30'd0, req_id}, 0);

      // IRQ level request, service, and re-request after done
      i_flag = 1'b0;
      expect_req(2'd2, 16'hFFFE);
      int_n = 3'b011;
      tick();
      chk("irq_req", {31'd0, req}, 1);
      chk("irq_pending", {29'd0, pending}, 32'b100);
      ack = 1'b1; tick(); ack = 1'b0;
      chk("irq_insvc", {31'd0, in_service}, 1);
      chk("irq_req_ack", {31'd0, req}, 0);
      tick(2);
      chk("svc_no_req", {31'd0, req}, 0);
      expect_req(2'd2, 16'hFFFE);
      done = 1'b1; tick(); done = 1'b0;
      chk("done_insvc", {31'd0, in_service}, 0);
      chk("done_req0", {31'd0, req}, 0);
      tick();
      chk("rereq", {31'd0, req}, 1);

      // withdrawal by i_flag, then non-maskable NMI edge
      i_flag = 1'b1;
      tick();
      chk("withdraw", {31'd0, req}, 0);
      expect_req(2'd1, 16'hFFFA);
      int_n = 3'b001;
      tick();
      chk("nmi_req", {31'd0, req}, 1);
      ack = 1'b1; tick(); ack = 1'b0;
      chk("nmi_cleared", {29'd0, pending}, 32'b100);
      int_n = 3'b011;
      done = 1'b1; tick(); done = 1'b0;
      tick();
      chk("irq_masked", {31'd0, req}, 0);

      // hijack: IRQ requesting, NMI edge takes over without a req gap
      i_flag = 1'b0;
      expect_req(2'd2, 16'hFFFE);
      tick();
      expect_req(2'd1, 16'hFFFA);
      int_n = 3'b001;
      tick();
      chk("hijack_req", {31'd0, req}, 1);
      ack = 1'b1; tick(); ack = 1'b0;
      chk("hijack_pending", {29'd0, pending}, 32'b100);
      int_n = 3'b011;
      expect_req(2'd2, 16'hFFFE);
      done = 1'b1; tick(); done = 1'b0;
      tick();

      // NMI edge on the same cycle IRQ is acked
      int_n = 3'b001; ack = 1'b1;
      tick();
      ack = 1'b0; int_n = 3'b011;
      chk("same_insvc", {31'd0, in_service}, 1);
      chk("same_nmi_pend", {31'd0, pending[1]}, 1);
      tick();
      chk("same_pending", {29'd0, pending}, 32'b110);
      expect_req(2'd1, 16'hFFFA);
      done = 1'b1; tick(); done = 1'b0;
      tick();
      chk("after_done_req", {31'd0, req}, 1);

      // reset during service with a latched NMI
      ack = 1'b1; tick(); ack = 1'b0;
      int_n = 3'b001; tick();
      int_n = 3'b011; tick();
      chk("pre_rst_latch", {31'd0, pending[1]}, 1);
      int_n = 3'b111; RES = 1'b1;
      tick();
      chk("mid_rst_req", {31'd0, req}, 0);
      chk("mid_rst_insvc", {31'd0, in_service}, 0);
      chk("mid_rst_pending", {29'd0, pending}, 0);
      chk("mid_rst_vec", {16'd0, req_vec}, 32'hFFFC);
      chk("mid_rst_id", {30'd0, req_id}, 0);
      RES = 1'b0;
      tick(3);
      chk("lost_edges", {29'd0, pending}, 0);
      chk("lost_req", {31'd0, req}, 0);

      // NMI held low across reset release yields exactly one edge
      RES = 1'b1; int_n = 3'b101;
      tick();
      expect_req(2'd1, 16'hFFFA);
      RES = 1'b0;
      tick();
      chk("held_req", {31'd0, req}, 1);
      ack = 1'b1; tick(); ack = 1'b0;
      done = 1'b1; tick(); done = 1'b0;
      tick(2);
      chk("held_once", {31'd0, req}, 0);

      chk("queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
